rx_frame_ctrlmod: RTL and testbench
===================================

// Module: rx_frame_ctrlmod
// PURPOSE
//  Downstream of the UART byte receiver (rx_funcmod): drives its iCall, consumes oDone/oData.
//  Assembles byte frames [0xAA][LEN][payload x LEN][SUM] into an internal buffer.
//  Verifies LEN and checksum, enforces an inter-byte timeout, then presents the payload
//  to the host through a read port until the host acknowledges the frame.
// PARAMETERS
//  MAX_LEN   16         max payload bytes accepted; LEN==0 or LEN>MAX_LEN is an error
//  TIMEOUT   20'd50000  max CLOCK cycles between iDone pulses once HEADER is seen (1 ms @50 MHz)
//  AW        4          buffer address width; 2**AW >= MAX_LEN
// PORTS
//  CLOCK      in   1   system clock
//  RESET      in   1   synchronous, active-high reset
//  oCall      out  1   to rx_funcmod iCall; high = byte receiver enabled
//  iDone      in   1   from rx_funcmod oDone; 1-cycle byte-valid pulse
//  iData      in   8   from rx_funcmod oData; valid in the iDone cycle
//  oFrameDone out  1   1-cycle pulse: good frame stored, buffer locked
//  oLen       out  8   payload length of locked frame; valid while locked
//  iRdAddr    in   AW  host read address
//  oRdData    out  8   buffer[iRdAddr], registered, 1-cycle latency
//  iAck       in   1   host releases locked frame
//  oErr       out  1   1-cycle pulse: frame discarded
//  oErrCode   out  2   1=BADLEN 2=BADSUM 3=TIMEOUT; held until next oErr
// BEHAVIOUR
//  Reset: state=HUNT, oCall=0 for exactly the reset cycle(s), then 1; oFrameDone=0, oErr=0,
//   oErrCode=0, oLen=0, oRdData=0, sum=0, count=0, timer=0. Buffer contents undefined.
//  States: HUNT -> LEN -> DATA -> SUM -> LOCK; any error -> HUNT.
//  HUNT: on iDone, iData==0xAA -> LEN; any other byte discarded silently. Timer idle.
//  LEN: on iDone: iData==0 or >MAX_LEN -> oErr, code 1, HUNT; else latch len, sum<=iData,
//   count<=0 -> DATA.
//  DATA: on iDone: buffer[count]<=iData, sum<=sum+iData (mod 256), count++; after count
//   reaches len-1 write -> SUM.
//  SUM: on iDone: iData==sum -> oFrameDone pulse next cycle, oLen<=len, LOCK;
//   else oErr, code 2, HUNT.
//  Timer: cleared on every iDone; counts in LEN/DATA/SUM; at TIMEOUT-1 -> oErr, code 3, HUNT.
//   Abort does NOT drop oCall (rx_funcmod has no abort; a frozen mid-byte receiver is forbidden).
//  oCall falls only in the cycle after the SUM-byte iDone (rx_funcmod is then idle at step 0).
//   Held 0 through LOCK; line traffic is ignored. Rises the cycle after iAck.
//  LOCK: buffer read-only; iAck -> HUNT, oCall=1 next cycle. iAck outside LOCK ignored.
//  oFrameDone/oErr are single-cycle, never simultaneous, and no more than one per frame.
//  iDone in the same cycle as timer expiry: the byte wins (timer cleared, no error).
//  oRdData is valid in every state; reads during reception return in-progress bytes.
//  Write and read at the same address in one cycle: old data returned.
//  Reset mid-frame: the partial frame is dropped with no oErr. rx_funcmod shares RESET.
// STRUCTURE
//  Shared package/include rx_frame_defs: HEADER=8'hAA, ERR_BADLEN=2'd1, ERR_BADSUM=2'd2,
//   ERR_TIMEOUT=2'd3, and the state encodings.
//  One sub-module: rx_frame_buffer. It is a simple dual-port RAM (2**AW x 8), with a sync write
//   and a registered read.
//  The top is FSM + sum/count/timer registers. Frame sizes are specified in bytes.
// TESTING (bench uses real rx_funcmod + a serial line BFM at 115200; plus direct iDone driver)
//  T1 AA 03 11 22 33 69 -> oFrameDone once, oLen=3, reads 0/1/2 = 11/22/33, oCall=0 until iAck.
//  T2 AA 03 11 22 33 68 -> oErr, oErrCode=2, no oFrameDone, oCall stays 1, next good frame passes.
//  T3 AA 00 and AA 11 (MAX_LEN=16) -> oErr code 1 each, parser back in HUNT.
//  T4 Bytes 5A 00 AA 01 7E 7F (junk then frame) -> frame accepted, oLen=1, buffer[0]=7E.
//  T5 AA 02 01 then silence > TIMEOUT -> oErr code 3. Then AA 01 05 06 -> oFrameDone.
//  T6 While locked, send AA 01 05 06 -> no reception. iAck, resend -> accepted.
//   Then assert RESET mid-DATA -> all outputs at reset values with no pulse.

Source files
------------

// File: rtl/rx_frame_defs.sv
// Shared constants for the UART frame receiver: header byte, error codes, FSM states.
package rx_frame_defs;

    localparam logic [7:0] HEADER      = 8'hAA;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_BADLEN  = 2'd1;
    localparam logic [1:0] ERR_BADSUM  = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    typedef enum logic [2:0] {
        ST_HUNT = 3'd0,
        ST_LEN  = 3'd1,
        ST_DATA = 3'd2,
        ST_SUM  = 3'd3,
        ST_LOCK = 3'd4
    } state_t;

endpackage

// File: rtl/rx_frame_buffer.sv
// Payload buffer: simple dual-port RAM, synchronous write, registered read.
// A read of the address being written in the same cycle returns the old byte.
module rx_frame_buffer #(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem_q [2**AW];
    logic [7:0] rd_data_d;
    logic [7:0] rd_data_q;

    // Read mux sees the array before this cycle's write lands.
    always_comb begin
        rd_data_d = mem_q[rd_addr];
    end

    // Storage array; contents are not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Registered read port, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/rx_frame_ctrlmod.sv
// Frame assembler behind the UART byte receiver: [AA][LEN][payload][SUM].
// SUM is LEN plus all payload bytes, modulo 256. The header is not summed.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  ST_HUNT | waiting for header byte, other bytes dropped, timer idle
//  ST_LEN  | header seen, waiting for length byte
//  ST_DATA | storing payload bytes into the buffer
//  ST_SUM  | waiting for checksum byte
//  ST_LOCK | good frame held for the host, receiver disabled until iAck
module rx_frame_ctrlmod
    import rx_frame_defs::*;
#(
    parameter int          MAX_LEN = 16,
    parameter logic [19:0] TIMEOUT = 20'd50000,
    parameter int          AW      = 4
) (
    input  logic          CLOCK,
    input  logic          RESET,
    output logic          oCall,
    input  logic          iDone,
    input  logic [7:0]    iData,
    output logic          oFrameDone,
    output logic [7:0]    oLen,
    input  logic [AW-1:0] iRdAddr,
    output logic [7:0]    oRdData,
    input  logic          iAck,
    output logic          oErr,
    output logic [1:0]    oErrCode
);

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    state_t        state_q, state_d;
    logic [7:0]    len_q, len_d;
    logic [7:0]    sum_q, sum_d;
    logic [AW-1:0] count_q, count_d;
    logic [19:0]   timer_q, timer_d;
    logic          call_q, call_d;
    logic          frame_done_q, frame_done_d;
    logic          err_q, err_d;
    logic [1:0]    err_code_q, err_code_d;
    logic [7:0]    out_len_q, out_len_d;
    logic          wr_en;
    logic          timer_expired;
    logic          last_payload;

    // The byte in the expiry cycle takes priority, so expiry is only acted on without iDone.
    assign timer_expired = (timer_q == TIMEOUT - 20'd1);
    assign last_payload  = ({{(8-AW){1'b0}}, count_q} == len_q - 8'd1);

    // Next-state logic for the parser, checksum, payload counter and inter-byte timer.
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        sum_d        = sum_q;
        count_d      = count_q;
        timer_d      = '0;
        call_d       = 1'b1;
        frame_done_d = 1'b0;
        err_d        = 1'b0;
        err_code_d   = err_code_q;
        out_len_d    = out_len_q;
        wr_en        = 1'b0;

        if ((state_q == ST_LEN || state_q == ST_DATA || state_q == ST_SUM) && !iDone) begin
            timer_d = timer_q + 20'd1;
        end

        case (state_q)
            ST_HUNT: begin
                if (iDone && iData == HEADER) begin
                    state_d = ST_LEN;
                end
            end
            ST_LEN: begin
                if (iDone) begin
                    if (iData == 8'd0 || iData > MAX_LEN_B) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_BADLEN;
                        state_d    = ST_HUNT;
                    end else begin
                        len_d   = iData;
                        sum_d   = iData;
                        count_d = '0;
                        state_d = ST_DATA;
                    end
                end else if (timer_expired) begin
                    err_d      = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                    timer_d    = '0;
                    state_d    = ST_HUNT;
                end
            end
            ST_DATA: begin
                if (iDone) begin
                    wr_en   = 1'b1;
                    sum_d   = sum_q + iData;
                    count_d = count_q + 1'b1;
                    if (last_payload) begin
                        state_d = ST_SUM;
                    end
                end else if (timer_expired) begin
                    err_d      = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                    timer_d    = '0;
                    state_d    = ST_HUNT;
                end
            end
            ST_SUM: begin
                if (iDone) begin
                    if (iData == sum_q) begin
                        frame_done_d = 1'b1;
                        out_len_d    = len_q;
                        call_d       = 1'b0;
                        state_d      = ST_LOCK;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = ERR_BADSUM;
                        state_d    = ST_HUNT;
                    end
                end else if (timer_expired) begin
                    err_d      = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                    timer_d    = '0;
                    state_d    = ST_HUNT;
                end
            end
            ST_LOCK: begin
                // Receiver stays disabled so the locked payload cannot be overwritten.
                call_d = 1'b0;
                if (iAck) begin
                    call_d  = 1'b1;
                    state_d = ST_HUNT;
                end
            end
            default: begin
                state_d = ST_HUNT;
            end
        endcase
    end

    // State and registered outputs; reset drops any partial frame without flagging an error.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q      <= ST_HUNT;
            len_q        <= '0;
            sum_q        <= '0;
            count_q      <= '0;
            timer_q      <= '0;
            call_q       <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
            err_code_q   <= ERR_NONE;
            out_len_q    <= '0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            sum_q        <= sum_d;
            count_q      <= count_d;
            timer_q      <= timer_d;
            call_q       <= call_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
            out_len_q    <= out_len_d;
        end
    end

    rx_frame_buffer #(
        .AW(AW)
    ) u_buffer (
        .clk     (CLOCK),
        .rst     (RESET),
        .wr_en   (wr_en),
        .wr_addr (count_q),
        .wr_data (iData),
        .rd_addr (iRdAddr),
        .rd_data (oRdData)
    );

    assign oCall      = call_q;
    assign oFrameDone = frame_done_q;
    assign oErr       = err_q;
    assign oErrCode   = err_code_q;
    assign oLen       = out_len_q;

endmodule

// File: tb/tb_rx_frame_ctrlmod.sv
// Bench for rx_frame_ctrlmod: direct iDone byte driver, frame-level reference model,
// per-cycle output comparison plus literal expectations for each scenario.
module tb_rx_frame_ctrlmod;

    localparam int MAX_LEN = 16;
    localparam int AW      = 4;
    localparam int TO      = 40;

    logic          CLOCK = 1'b0;
    logic          RESET;
    logic          oCall;
    logic          iDone;
    logic [7:0]    iData;
    logic          oFrameDone;
    logic [7:0]    oLen;
    logic [AW-1:0] iRdAddr;
    logic [7:0]    oRdData;
    logic          iAck;
    logic          oErr;
    logic [1:0]    oErrCode;

    int checks   = 0;
    int failures = 0;

    always #5 CLOCK = ~CLOCK;

    rx_frame_ctrlmod #(
        .MAX_LEN (MAX_LEN),
        .TIMEOUT (20'(TO)),
        .AW      (AW)
    ) dut (
        .CLOCK      (CLOCK),
        .RESET      (RESET),
        .oCall      (oCall),
        .iDone      (iDone),
        .iData      (iData),
        .oFrameDone (oFrameDone),
        .oLen       (oLen),
        .iRdAddr    (iRdAddr),
        .oRdData    (oRdData),
        .iAck       (iAck),
        .oErr       (oErr),
        .oErrCode   (oErrCode)
    );

    // ---------------- reference model (frame level) ----------------
    int  m_frame[$];
    int  m_gap = 0;
    bit  m_locked = 0;
    bit  m_call = 0, m_fd = 0, m_err = 0;
    int  m_code = 0, m_len = 0, m_rd = 0;
    bit  m_rd_known = 0;
    int  mem[16];
    bit  known[16];
    bit  m_valid = 0;
    int  n_fd = 0, n_err = 0;

    task automatic model_error(input int code);
        m_err  = 1;
        m_code = code;
        m_frame.delete();
        m_gap  = 0;
    endtask

    task automatic model_step();
        int n;
        int s;
        if (RESET) begin
            m_frame.delete();
            m_gap = 0; m_locked = 0; m_call = 0; m_fd = 0; m_err = 0;
            m_code = 0; m_len = 0; m_rd = 0; m_rd_known = 1;
        end else begin
            m_rd       = mem[iRdAddr];
            m_rd_known = known[iRdAddr];
            m_fd  = 0;
            m_err = 0;
            if (m_locked) begin
                if (iAck) begin
                    m_locked = 0;
                    m_call   = 1;
                end else begin
                    m_call = 0;
                end
            end else begin
                m_call = 1;
                if (iDone) begin
                    m_gap = 0;
                    if (m_frame.size() == 0) begin
                        if (iData == 8'hAA) m_frame.push_back(int'(iData));
                    end else begin
                        m_frame.push_back(int'(iData));
                        n = m_frame.size();
                        if (n == 2) begin
                            if (iData == 8'd0 || int'(iData) > MAX_LEN) model_error(1);
                        end else if (n <= m_frame[1] + 2) begin
                            mem[n-3]   = int'(iData);
                            known[n-3] = 1;
                        end else begin
                            s = 0;
                            for (int i = 1; i < n - 1; i++) s += m_frame[i];
                            if ((s % 256) == int'(iData)) begin
                                m_fd     = 1;
                                m_len    = m_frame[1];
                                m_locked = 1;
                                m_call   = 0;
                                m_frame.delete();
                            end else begin
                                model_error(2);
                            end
                        end
                    end
                end else if (m_frame.size() != 0) begin
                    m_gap++;
                    if (m_gap == TO) model_error(3);
                end
            end
        end
        m_valid = 1;
    endtask

    initial begin
        forever begin
            @(posedge CLOCK);
            model_step();
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model, on the falling edge.
    initial begin
        forever begin
            @(negedge CLOCK);
            if (m_valid) begin
                chk("cyc_oCall",      32'(oCall),      32'(m_call));
                chk("cyc_oFrameDone", 32'(oFrameDone), 32'(m_fd));
                chk("cyc_oErr",       32'(oErr),       32'(m_err));
                chk("cyc_oErrCode",   32'(oErrCode),   32'(m_code));
                chk("cyc_oLen",       32'(oLen),       32'(m_len));
                if (m_rd_known) chk("cyc_oRdData", 32'(oRdData), 32'(m_rd));
            end
            if (oFrameDone) n_fd++;
            if (oErr) n_err++;
        end
    end

    // ---------------- stimulus helpers (each leaves time at posedge+1) ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge CLOCK);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        iDone = 1'b1;
        iData = b;
        tick(1);
        iDone = 1'b0;
        iData = 8'($urandom);
        if (gap > 0) tick(gap);
    endtask

    task automatic send_q(input int q[$], input int gap);
        foreach (q[i]) send(8'(q[i]), gap);
    endtask

    task automatic rd(input int a, input int exp, input string name);
        iRdAddr = AW'(a);
        tick(1);
        chk(name, 32'(oRdData), 32'(exp));
    endtask

    task automatic ack();
        iAck = 1'b1;
        tick(1);
        iAck = 1'b0;
        tick(1);
    endtask

    int q[$];
    int fd0, err0;

    initial begin
        RESET = 1'b1; iDone = 1'b0; iData = 8'h00; iRdAddr = '0; iAck = 1'b0;
        tick(3);
        chk("rst_oCall", 32'(oCall), 0);
        chk("rst_oErr", 32'(oErr), 0);
        chk("rst_oErrCode", 32'(oErrCode), 0);
        chk("rst_oLen", 32'(oLen), 0);
        chk("rst_oRdData", 32'(oRdData), 0);
        RESET = 1'b0;
        tick(1);
        chk("post_rst_oCall", 32'(oCall), 1);

        // T1: good 3-byte frame
        fd0 = n_fd; err0 = n_err;
        q = '{8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
        send_q(q, 1);
        tick(2);
        chk("t1_fd_count", 32'(n_fd - fd0), 1);
        chk("t1_err_count", 32'(n_err - err0), 0);
        chk("t1_oLen", 32'(oLen), 3);
        chk("t1_oCall_locked", 32'(oCall), 0);
        rd(0, 8'h11, "t1_rd0");
        rd(1, 8'h22, "t1_rd1");
        rd(2, 8'h33, "t1_rd2");

        // T6a: traffic while locked is ignored
        q = '{8'hAA, 8'h01, 8'h05, 8'h06};
        send_q(q, 0);
        tick(2);
        chk("t6_locked_fd", 32'(n_fd - fd0), 1);
        rd(0, 8'h11, "t6_locked_rd0");
        ack();
        chk("t6_ack_oCall", 32'(oCall), 1);
        fd0 = n_fd;
        send_q(q, 0);
        tick(2);
        chk("t6_resend_fd", 32'(n_fd - fd0), 1);
        chk("t6_resend_oLen", 32'(oLen), 1);
        rd(0, 8'h05, "t6_resend_rd0");
        ack();

        // T2: bad checksum, then a good frame
        fd0 = n_fd; err0 = n_err;
        q = '{8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h68};
        send_q(q, 0);
        tick(2);
        chk("t2_err_count", 32'(n_err - err0), 1);
        chk("t2_code", 32'(oErrCode), 2);
        chk("t2_no_fd", 32'(n_fd - fd0), 0);
        chk("t2_oCall", 32'(oCall), 1);
        q = '{8'hAA, 8'h02, 8'h01, 8'h02, 8'h05};
        send_q(q, 0);
        tick(2);
        chk("t2_good_fd", 32'(n_fd - fd0), 1);
        chk("t2_good_oLen", 32'(oLen), 2);
        ack();

        // T3: bad lengths, then max-length frame
        err0 = n_err;
        q = '{8'hAA, 8'h00};
        send_q(q, 0);
        tick(2);
        chk("t3_len0_code", 32'(oErrCode), 1);
        q = '{8'hAA, 8'h11};
        send_q(q, 0);
        tick(2);
        chk("t3_len17_code", 32'(oErrCode), 1);
        chk("t3_err_count", 32'(n_err - err0), 2);
        fd0 = n_fd;
        q.delete();
        q.push_back(8'hAA);
        q.push_back(8'h10);
        for (int i = 0; i < 16; i++) q.push_back(i);
        q.push_back(8'h88);
        send_q(q, 0);
        tick(2);
        chk("t3_max_fd", 32'(n_fd - fd0), 1);
        chk("t3_max_oLen", 32'(oLen), 16);
        rd(15, 8'h0F, "t3_max_rd15");
        ack();

        // iAck outside LOCK is ignored
        ack();
        chk("stray_ack_oCall", 32'(oCall), 1);

        // T4: junk before header
        fd0 = n_fd;
        q = '{8'h5A, 8'h00, 8'hAA, 8'h01, 8'h7E, 8'h7F};
        send_q(q, 2);
        tick(1);
        chk("t4_fd", 32'(n_fd - fd0), 1);
        chk("t4_oLen", 32'(oLen), 1);
        rd(0, 8'h7E, "t4_rd0");
        ack();

        // T5: timeout, then a frame whose gaps sit exactly at the limit
        err0 = n_err; fd0 = n_fd;
        send(8'hAA, 0);
        send(8'h02, 0);
        send(8'h01, TO + 5);
        chk("t5_to_count", 32'(n_err - err0), 1);
        chk("t5_to_code", 32'(oErrCode), 3);
        chk("t5_to_oCall", 32'(oCall), 1);
        send(8'hAA, TO - 1);
        send(8'h01, TO - 1);
        send(8'h05, TO - 1);
        send(8'h06, 0);
        tick(2);
        chk("t5_edge_fd", 32'(n_fd - fd0), 1);
        chk("t5_edge_err", 32'(n_err - err0), 1);
        ack();

        // T6b: reset in the middle of DATA
        fd0 = n_fd; err0 = n_err;
        q = '{8'hAA, 8'h04, 8'h01, 8'h02};
        send_q(q, 0);
        RESET = 1'b1;
        tick(2);
        chk("t6_rst_oCall", 32'(oCall), 0);
        chk("t6_rst_oErrCode", 32'(oErrCode), 0);
        chk("t6_rst_oLen", 32'(oLen), 0);
        chk("t6_rst_oRdData", 32'(oRdData), 0);
        RESET = 1'b0;
        tick(1);
        chk("t6_after_rst_oCall", 32'(oCall), 1);
        tick(TO + 5);
        chk("t6_rst_no_err", 32'(n_err - err0), 0);
        chk("t6_rst_no_fd", 32'(n_fd - fd0), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
